// File: rtl/n64_bus_router_pkg.sv
// Shared types and address-map constants for the PI-side bus router.
// Device IDs follow sc64 numbering; NUM_DEV_IDS tracks the enum.
package n64_bus_router_pkg;

  typedef enum logic [2:0] {
    ID_N64_SDRAM      = 3'd0,
    ID_N64_BOOTLOADER = 3'd1,
    ID_N64_FLASHRAM   = 3'd2,
    ID_N64_DD         = 3'd3,
    ID_N64_CFG        = 3'd4
  } dev_id_e;

  localparam int NUM_DEV_IDS = int'(ID_N64_CFG) + 1;

  localparam logic [31:0] DD_BASE       = 32'h0500_0000;
  localparam logic [31:0] DD_SIZE       = 32'h0100_0000;
  localparam logic [31:0] FLASHRAM_BASE = 32'h0800_0000;
  localparam logic [31:0] FLASHRAM_SIZE = 32'h0002_0000;
  localparam logic [31:0] SDRAM_BASE    = 32'h1000_0000;
  localparam logic [31:0] SDRAM_SIZE    = 32'h0400_0000;
  localparam logic [31:0] CFG_BASE      = 32'h1E00_0000;
  localparam logic [31:0] CFG_SIZE      = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESPOND  = 2'd2
  } state_e;

  // Unsigned wrap makes addresses below base fall outside the window.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/n64_bus_decoder.sv
// Combinational PI address map: address + live cfg enables -> {mapped, id}.
module n64_bus_decoder
  import n64_bus_router_pkg::*;
(
  input  logic [31:0] address,
  input  logic        cfg_sdram_switch,
  input  logic        cfg_flashram_enabled,
  input  logic        cfg_dd_enabled,
  output logic        mapped,
  output logic [2:0]  id
);

  always_comb begin
    mapped = 1'b0;
    id     = ID_N64_SDRAM;
    if (cfg_dd_enabled && in_window(address, DD_BASE, DD_SIZE)) begin
      mapped = 1'b1;
      id     = ID_N64_DD;
    end else if (cfg_flashram_enabled && in_window(address, FLASHRAM_BASE, FLASHRAM_SIZE)) begin
      mapped = 1'b1;
      id     = ID_N64_FLASHRAM;
    end else if (in_window(address, SDRAM_BASE, SDRAM_SIZE)) begin
      mapped = 1'b1;
      id     = cfg_sdram_switch ? ID_N64_SDRAM : ID_N64_BOOTLOADER;
    end else if (in_window(address, CFG_BASE, CFG_SIZE)) begin
      mapped = 1'b1;
      id     = ID_N64_CFG;
    end
  end

endmodule

// File: rtl/n64_bus_router.sv
// Routes one PI transaction at a time to a single device, waits for its ack
// under a timeout and returns data/status; unmapped or stalled accesses error out.
module n64_bus_router
  import n64_bus_router_pkg::*;
#(
  parameter int          NUM_DEVICES    = NUM_DEV_IDS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] OPEN_BUS_DATA  = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pi_request,
  input  logic                      pi_write,
  input  logic [31:0]               pi_address,
  input  logic [15:0]               pi_wdata,
  output logic                      pi_ack,
  output logic [15:0]               pi_rdata,
  output logic                      pi_error,
  output logic                      overrun,
  input  logic                      cfg_sdram_switch,
  input  logic                      cfg_flashram_enabled,
  input  logic                      cfg_dd_enabled,
  output logic [NUM_DEVICES-1:0]    dev_request,
  output logic                      dev_write,
  output logic [31:0]               dev_address,
  output logic [15:0]               dev_wdata,
  input  logic [NUM_DEVICES-1:0]    dev_ack,
  input  logic [NUM_DEVICES*16-1:0] dev_rdata
);

  logic                         dec_mapped;
  logic [2:0]                   dec_id;
  logic [2:0]                   sel_id;
  logic [7:0]                   timer;
  state_e                       state;
  logic [NUM_DEVICES-1:0][15:0] rdata_arr;

  assign rdata_arr = dev_rdata;

  n64_bus_decoder u_dec (
    .address              (pi_address),
    .cfg_sdram_switch     (cfg_sdram_switch),
    .cfg_flashram_enabled (cfg_flashram_enabled),
    .cfg_dd_enabled       (cfg_dd_enabled),
    .mapped               (dec_mapped),
    .id                   (dec_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      sel_id      <= '0;
      pi_ack      <= 1'b0;
      pi_rdata    <= '0;
      pi_error    <= 1'b0;
      overrun     <= 1'b0;
      dev_request <= '0;
      dev_write   <= 1'b0;
      dev_address <= '0;
      dev_wdata   <= '0;
    end else begin
      pi_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pi_request) begin
            if (dec_mapped) begin
              sel_id      <= dec_id;
              dev_request <= NUM_DEVICES'(1) << dec_id;
              dev_write   <= pi_write;
              dev_address <= pi_address;
              dev_wdata   <= pi_wdata;
              timer       <= 8'(TIMEOUT_CYCLES);
              state       <= ST_WAIT_ACK;
            end else begin
              pi_ack   <= 1'b1;
              pi_error <= 1'b1;
              pi_rdata <= OPEN_BUS_DATA;
              state    <= ST_RESPOND;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (pi_request) overrun <= 1'b1;
          // Ack is checked before expiry so a last-cycle ack still succeeds.
          if (dev_ack[sel_id]) begin
            dev_request <= '0;
            pi_ack      <= 1'b1;
            pi_error    <= 1'b0;
            pi_rdata    <= rdata_arr[sel_id];
            state       <= ST_RESPOND;
          end else if (timer <= 8'd1) begin
            timer       <= '0;
            dev_request <= '0;
            pi_ack      <= 1'b1;
            pi_error    <= 1'b1;
            pi_rdata    <= OPEN_BUS_DATA;
            state       <= ST_RESPOND;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ST_RESPOND: begin
          if (pi_request) overrun <= 1'b1;
          pi_error <= 1'b0;
          pi_rdata <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_bus_router.sv
// Directed + randomized bench for n64_bus_router against a transaction-level model.
module tb_n64_bus_router;

  localparam int          NUM  = 5;
  localparam int          TO   = 4;
  localparam logic [15:0] OPEN = 16'h0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              pi_request, pi_write;
  logic [31:0]       pi_address;
  logic [15:0]       pi_wdata;
  logic              pi_ack, pi_error, overrun;
  logic [15:0]       pi_rdata;
  logic              cfg_sdram_switch, cfg_flashram_enabled, cfg_dd_enabled;
  logic [NUM-1:0]    dev_request;
  logic              dev_write;
  logic [31:0]       dev_address;
  logic [15:0]       dev_wdata;
  logic [NUM-1:0]    dev_ack;
  logic [NUM*16-1:0] dev_rdata;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  exp_overrun = 1'b0;

  always #5 clk = ~clk;

  n64_bus_router #(.NUM_DEVICES(NUM), .TIMEOUT_CYCLES(TO), .OPEN_BUS_DATA(OPEN)) dut (
    .clk(clk), .reset(reset),
    .pi_request(pi_request), .pi_write(pi_write), .pi_address(pi_address), .pi_wdata(pi_wdata),
    .pi_ack(pi_ack), .pi_rdata(pi_rdata), .pi_error(pi_error), .overrun(overrun),
    .cfg_sdram_switch(cfg_sdram_switch), .cfg_flashram_enabled(cfg_flashram_enabled),
    .cfg_dd_enabled(cfg_dd_enabled),
    .dev_request(dev_request), .dev_write(dev_write), .dev_address(dev_address),
    .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference address map written as inclusive ranges.
  function automatic void ref_decode(input logic [31:0] a, input bit sw, input bit fl, input bit dd,
                                     output bit m, output int id);
    m = 1'b1;
    if (dd && a >= 32'h0500_0000 && a <= 32'h05FF_FFFF)      id = 3;
    else if (fl && a >= 32'h0800_0000 && a <= 32'h0801_FFFF) id = 2;
    else if (a >= 32'h1000_0000 && a <= 32'h13FF_FFFF)      id = sw ? 0 : 1;
    else if (a >= 32'h1E00_0000 && a <= 32'h1E00_FFFF)      id = 4;
    else begin m = 1'b0; id = 0; end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(pi_ack), 0);
    chk({tag, "_rdata"}, 32'(pi_rdata), 0);
    chk({tag, "_err"},   32'(pi_error), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
    chk({tag, "_req"},   32'(dev_request), 0);
    chk({tag, "_wr"},    32'(dev_write), 0);
    chk({tag, "_addr"},  dev_address, 0);
    chk({tag, "_wd"},    32'(dev_wdata), 0);
  endtask

  // ack_at: WAIT_ACK cycle index (0 = first dev_request cycle) at which the
  // selected device acks; negative means it never acks.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [15:0] wd,
                     input int ack_at, input logic [15:0] rd, input bit noise);
    bit m; int id; int last; bit ack_ok; int k;
    ref_decode(addr, cfg_sdram_switch, cfg_flashram_enabled, cfg_dd_enabled, m, id);
    pi_request = 1'b1; pi_write = wr; pi_address = addr; pi_wdata = wd;
    tick();
    pi_request = 1'b0; pi_write = 1'($urandom); pi_address = $urandom; pi_wdata = 16'($urandom);
    if (!m) begin
      chk("unmap_ack",    32'(pi_ack), 1);
      chk("unmap_err",    32'(pi_error), 1);
      chk("unmap_rdata",  32'(pi_rdata), 32'(OPEN));
      chk("unmap_devreq", 32'(dev_request), 0);
    end else begin
      ack_ok = (ack_at >= 0) && (ack_at < TO);
      last   = ack_ok ? ack_at : TO - 1;
      for (int c = 0; c <= last; c++) begin
        chk("devreq",   32'(dev_request), 32'(1 << id));
        chk("dev_addr", dev_address, addr);
        chk("dev_wr",   32'(dev_write), 32'(wr));
        chk("dev_wd",   32'(dev_wdata), 32'(wd));
        chk("no_early_ack", 32'(pi_ack), 0);
        if (noise) begin
          cfg_sdram_switch = 1'($urandom); cfg_flashram_enabled = 1'($urandom);
          cfg_dd_enabled = 1'($urandom);
          if (c == 0 || $urandom_range(0, 1) == 1) begin
            pi_request = 1'b1; exp_overrun = 1'b1;
          end
          k = (id + 2) % NUM;
          dev_ack[k] = 1'b1;
          dev_rdata[k*16 +: 16] = 16'hDEAD;
        end
        if (c == ack_at) begin
          dev_ack[id] = 1'b1;
          dev_rdata[id*16 +: 16] = rd;
        end
        tick();
        dev_ack = '0; pi_request = 1'b0; dev_rdata = {NUM{16'h5A5A}};
      end
      chk("ack",    32'(pi_ack), 1);
      chk("err",    32'(pi_error), 32'(!ack_ok));
      if (!wr) chk("rdata", 32'(pi_rdata), ack_ok ? 32'(rd) : 32'(OPEN));
      chk("devreq_drop", 32'(dev_request), 0);
    end
    if (noise) begin
      if ($urandom_range(0, 1) == 1) begin pi_request = 1'b1; exp_overrun = 1'b1; end
      dev_ack = 5'($urandom);
    end
    tick();
    pi_request = 1'b0; dev_ack = '0;
    chk("ack_pulse", 32'(pi_ack), 0);
    chk("overrun",   32'(overrun), 32'(exp_overrun));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h0500_0000 | ($urandom & 32'h00FF_FFFF);
      1:       return 32'h0800_0000 | ($urandom & 32'h0001_FFFF);
      2:       return 32'h1000_0000 | ($urandom & 32'h03FF_FFFF);
      3:       return 32'h1E00_0000 | ($urandom & 32'h0000_FFFF);
      4:       return 32'h0802_0000 + ($urandom & 32'h0000_000F);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] bnd [10];

  initial begin
    reset = 1'b1; pi_request = 1'b0; pi_write = 1'b0; pi_address = '0; pi_wdata = '0;
    cfg_sdram_switch = 1'b1; cfg_flashram_enabled = 1'b0; cfg_dd_enabled = 1'b0;
    dev_ack = '0; dev_rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // SDRAM read, ack on the third dev_request cycle
    txn(1'b0, 32'h1000_0000, 16'h0, 2, 16'hBEEF, 1'b0);
    // bootloader window and cfg write
    cfg_sdram_switch = 1'b0;
    txn(1'b0, 32'h1000_0000, 16'h0, 0, 16'h1111, 1'b0);
    txn(1'b1, 32'h1E00_0004, 16'h1234, 1, 16'h0, 1'b0);
    // flashram disabled then enabled
    txn(1'b1, 32'h0800_0000, 16'h00AA, 0, 16'h0, 1'b0);
    cfg_flashram_enabled = 1'b1;
    txn(1'b1, 32'h0800_0000, 16'h00AA, 0, 16'h0, 1'b0);
    // DD timeout, then ack exactly in the expiry cycle
    cfg_dd_enabled = 1'b1;
    txn(1'b0, 32'h0500_0000, 16'h0, -1, 16'h0, 1'b0);
    txn(1'b0, 32'h05FF_FFFE, 16'h0, TO - 1, 16'h7777, 1'b0);
    // overrun during WAIT_ACK plus stray ack on device 2 while SDRAM selected
    cfg_sdram_switch = 1'b1; cfg_flashram_enabled = 1'b1; cfg_dd_enabled = 1'b1;
    txn(1'b0, 32'h1000_0010, 16'h0, 2, 16'hC0DE, 1'b1);
    txn(1'b0, 32'h1000_0020, 16'h0, 1, 16'h0042, 1'b0);

    // window edges, with windows enabled and disabled
    bnd = '{32'h04FF_FFFF, 32'h0500_0000, 32'h05FF_FFFF, 32'h0600_0000, 32'h0801_FFFF,
            32'h0802_0000, 32'h13FF_FFFF, 32'h1400_0000, 32'h1E00_FFFF, 32'h1E01_0000};
    for (int p = 0; p < 2; p++) begin
      cfg_flashram_enabled = (p == 0); cfg_dd_enabled = (p == 0);
      for (int i = 0; i < 10; i++) txn(1'b0, bnd[i], 16'h0, 0, 16'(16'h0100 + i), 1'b0);
    end

    // reset in WAIT_ACK abandons the access
    cfg_sdram_switch = 1'b1;
    pi_request = 1'b1; pi_write = 1'b0; pi_address = 32'h1000_0100;
    tick();
    pi_request = 1'b0;
    chk("pre_rst_req", 32'(dev_request), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_overrun = 1'b0;
    chk_all_zero("midrst");
    dev_ack = 5'b00001;
    tick();
    dev_ack = '0;
    chk("post_rst_ack", 32'(pi_ack), 0);
    tick();
    txn(1'b0, 32'h1000_0200, 16'h0, 0, 16'hA5A5, 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      cfg_sdram_switch = 1'($urandom); cfg_flashram_enabled = 1'($urandom);
      cfg_dd_enabled = 1'($urandom);
      txn(1'($urandom), rand_addr(), 16'($urandom), $urandom_range(0, 6) - 1,
          16'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
